config_port_arbiter: RTL and testbench
======================================

# config_port_arbiter

Shares the fabric configuration write port between two bitstream sources: a byte-wide UART loader and a word-wide bus master. It grants one source for a whole configuration session and packs bytes into 32-bit words. It issues the session-start reset pulse and registered WriteData/WriteStrobe toward the configuration FSM. The block tracks the sync/header/frame word sequence so that it releases the port only at a desync header or on idle timeout.

## Interface
Parameters:
- NumberOfRows, 10, data words per frame after each non-desync header.
- DesyncFlag, 20, header bit index that ends a session.
- TimeoutCycles, 4000, idle cycles while granted before forced release (16-bit counter, 1..65535).

Ports:
- CLK  in  1  clock, all logic on posedge.
- Reset  in  1  asynchronous, active-high; clears all state.
- ByteData  in  8  UART byte.
- ByteValid  in  1  byte available.
- ByteReady  out  1  byte accepted when ByteValid && ByteReady.
- WordData  in  32  bus word.
- WordValid  in  1  word available.
- WordReady  out  1  word accepted when WordValid && WordReady.
- WriteData  out  32  word to the configuration FSM.
- WriteStrobe  out  1  one-cycle qualifier for WriteData.
- CfgReset  out  1  session-start pulse to the configuration FSM reset input (rising-edge sensitive there).
- Grant  out  2  one-hot owner: bit0 = word port, bit1 = byte port; 00 = idle.
- Timeout  out  1  one-cycle pulse on forced release.

## Operation
- Reset values: all outputs 0. State is IDLE. The last-granted pointer is set to the byte port, so the word port wins first. The byte counter is 0.
- States: IDLE, ARM, UNSYNC, HEADER, FRAME, CLOSE.
- IDLE:
  - A request is WordValid (word port) or ByteValid (byte port).
  - When only one port requests, that port is granted.
  - When both request, the port that was not last granted is granted (round-robin).
  - On the next cycle Grant is set and the state goes to ARM.
- ARM: CfgReset is held high for exactly 2 cycles, then the state goes to UNSYNC. Both Ready outputs are 0 during ARM.
- Accepting states (UNSYNC/HEADER/FRAME):
  - Only the granted port's Ready may be 1. The non-granted Ready is 0.
  - Word port: WordReady = 1. Each transfer registers WordData onto WriteData and pulses WriteStrobe on the next cycle. Throughput is one word per cycle.
  - Byte port: ByteReady = 1. Bytes are packed MSB-first: the 1st byte goes to [31:24] and the 4th byte to [7:0]. On the 4th transfer the packed word is presented with WriteStrobe on the next cycle, and the byte counter wraps to 0.
- Each emitted word is classified (classification uses the emitted value):
  - UNSYNC: the word 32'hFAB0_FAB1 moves the state to HEADER. Any other word is forwarded and the state stays UNSYNC.
  - HEADER: if bit DesyncFlag is 1, the word is forwarded and the state goes to CLOSE. Otherwise the frame counter is loaded with NumberOfRows and the state goes to FRAME.
  - FRAME: the counter decrements on each word. The word emitted when the counter equals 1 returns the state to HEADER. Bit DesyncFlag of frame data is ignored.
- Timeout:
  - The idle counter clears on every accepted byte or word and counts in accepting states otherwise.
  - When the count reaches TimeoutCycles, the state goes to CLOSE, Timeout pulses, and any partially packed bytes are discarded.
- CLOSE: lasts 1 cycle. Grant goes to 00, the last-granted pointer is updated, the byte counter is cleared, and the state returns to IDLE.
- Asynchronous Reset mid-session: everything clears immediately. A WriteStrobe in flight is dropped.

## Timing
- IDLE request seen at edge t: Grant is valid after t+1. CfgReset is high for the cycles following t+1 and t+2. Ready is first high after t+3.
- Word latency: accept at edge n, WriteStrobe and WriteData valid in cycle n+1, for one cycle only.
- Byte latency: 4th byte accepted at edge n, WriteStrobe valid in cycle n+1.
- A desync header emitted in cycle n: CLOSE in cycle n+1, Grant = 00 in cycle n+2. A new grant can be issued at the earliest at edge n+2.
- Ready outputs are combinational from state and grant only. They never depend on Valid.
- WriteStrobe is never high in two consecutive cycles from the byte port. It is never high during ARM, CLOSE or IDLE, except for the single word emitted at the CLOSE transition.

## Test plan
- Word session: word port sends FAB0_FAB1, header 0x0000_0001, then 10 data words, then header 0x0010_0000 (bit 20 set). Required: 13 strobes with the same data, in order. CfgReset is 2 cycles wide before the first word. Grant returns to 00 two cycles after the last strobe.
- Byte packing: bytes FA,B0,FA,B1 -> one strobe with WriteData = 0xFAB0_FAB1, one cycle after the 4th byte.
- Frame data with bit 20 set: frame word 0x0010_0000 in FRAME -> the session stays granted, and the following header is still expected.
- Contention: both Valid held in IDLE after reset -> word port is granted first, and the byte port is granted after the word port's desync. ByteReady stays 0 throughout the word session.
- Timeout: byte port sends 2 bytes, then is silent for 4000 cycles -> Timeout pulses once, Grant goes to 00, and no strobe is emitted. The next session starts with an empty packer.
- Async reset asserted mid-FRAME -> all outputs are 0 in the same cycle. After release, the word port wins the first grant.

Source files
------------

// File: rtl/config_port_arbiter.sv
// Shares the configuration write port between a UART byte loader and a bus word master.
// Grants one source per session, packs bytes MSB-first and follows sync/header/frame words.
module config_port_arbiter #(
    parameter int NumberOfRows  = 10,
    parameter int DesyncFlag    = 20,
    parameter int TimeoutCycles = 4000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  ByteData,
    input  logic        ByteValid,
    output logic        ByteReady,
    input  logic [31:0] WordData,
    input  logic        WordValid,
    output logic        WordReady,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        CfgReset,
    output logic [1:0]  Grant,
    output logic        Timeout
);
    typedef enum logic [2:0] {IDLE, ARM, UNSYNC, HEADER, FRAME, CLOSE} state_t;

    localparam logic [31:0] SyncWord    = 32'hFAB0_FAB1;
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
    localparam logic [15:0] RowsInit    = 16'(NumberOfRows);

    state_t      r_state;
    state_t      w_stateNext;
    logic [1:0]  r_grant;
    logic [1:0]  w_grantNext;
    logic        r_lastByte;
    logic        r_armCnt;
    logic [1:0]  r_byteCnt;
    logic [23:0] r_pack;
    logic [31:0] r_writeData;
    logic        r_writeStrobe;
    logic        r_timeout;
    logic [15:0] r_idleCnt;
    logic [15:0] r_frameCnt;
    logic        w_accepting;
    logic        w_wordXfer;
    logic        w_byteXfer;
    logic        w_packDone;
    logic        w_xfer;
    logic        w_timeoutHit;

    assign w_accepting = (r_state == UNSYNC) || (r_state == HEADER) || (r_state == FRAME);
    assign WordReady   = w_accepting && r_grant[0];
    assign ByteReady   = w_accepting && r_grant[1];
    assign w_wordXfer  = WordValid && WordReady;
    assign w_byteXfer  = ByteValid && ByteReady;
    assign w_packDone  = w_byteXfer && (r_byteCnt == 2'd3);
    assign w_xfer      = w_wordXfer || w_byteXfer;

    assign WriteData   = r_writeData;
    assign WriteStrobe = r_writeStrobe;
    assign CfgReset    = (r_state == ARM);
    assign Grant       = r_grant;
    assign Timeout     = r_timeout;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_stateNext;
            r_grant <= w_grantNext;
        end
    end

    // Words are classified the cycle they appear on WriteData, so the state tracks emitted values.
    always_comb begin
        w_stateNext  = r_state;
        w_grantNext  = r_grant;
        w_timeoutHit = 1'b0;
        case (r_state)
            IDLE: begin
                if (WordValid && (!ByteValid || r_lastByte)) begin
                    w_grantNext = 2'b01;
                    w_stateNext = ARM;
                end else if (ByteValid) begin
                    w_grantNext = 2'b10;
                    w_stateNext = ARM;
                end
            end
            ARM: begin
                if (r_armCnt) begin
                    w_stateNext = UNSYNC;
                end
            end
            UNSYNC, HEADER, FRAME: begin
                if (!w_xfer && (r_idleCnt == TimeoutLast)) begin
                    w_timeoutHit = 1'b1;
                    w_stateNext  = CLOSE;
                end else if (r_writeStrobe) begin
                    if (r_state == UNSYNC) begin
                        if (r_writeData == SyncWord) begin
                            w_stateNext = HEADER;
                        end
                    end else if (r_state == HEADER) begin
                        w_stateNext = r_writeData[DesyncFlag] ? CLOSE : FRAME;
                    end else if (r_frameCnt == 16'd1) begin
                        w_stateNext = HEADER;
                    end
                end
            end
            CLOSE: begin
                w_grantNext = 2'b00;
                w_stateNext = IDLE;
            end
            default: begin
                w_grantNext = 2'b00;
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_lastByte    <= 1'b1;
            r_armCnt      <= 1'b0;
            r_byteCnt     <= 2'd0;
            r_pack        <= '0;
            r_writeData   <= '0;
            r_writeStrobe <= 1'b0;
            r_timeout     <= 1'b0;
            r_idleCnt     <= '0;
            r_frameCnt    <= '0;
        end else begin
            r_armCnt      <= (r_state == ARM) ? ~r_armCnt : 1'b0;
            r_timeout     <= w_timeoutHit;
            r_writeStrobe <= w_wordXfer || w_packDone;
            if (w_wordXfer) begin
                r_writeData <= WordData;
            end else if (w_packDone) begin
                r_writeData <= {r_pack, ByteData};
            end
            // A partial word left by a timeout is dropped by clearing the count on close.
            if (r_state == CLOSE) begin
                r_byteCnt  <= 2'd0;
                r_lastByte <= r_grant[1];
            end else if (w_byteXfer) begin
                r_byteCnt <= r_byteCnt + 2'd1;
                r_pack    <= {r_pack[15:0], ByteData};
            end
            if (!w_accepting || w_xfer || w_timeoutHit) begin
                r_idleCnt <= '0;
            end else begin
                r_idleCnt <= r_idleCnt + 16'd1;
            end
            if (r_writeStrobe && (r_state == HEADER) && !r_writeData[DesyncFlag]) begin
                r_frameCnt <= RowsInit;
            end else if (r_writeStrobe && (r_state == FRAME)) begin
                r_frameCnt <= r_frameCnt - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: a session-level model predicts all outputs every cycle,
// and hand-computed literals pin word sequences, pulse widths, grant order and timeout behaviour.
module tb_config_port_arbiter;
    localparam int Rows = 10;
    localparam int Flag = 20;
    localparam int Tmo  = 4000;
    localparam logic [31:0] Sync = 32'hFAB0_FAB1;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  ByteData = 8'h00;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic [31:0] WordData = 32'h0;
    logic        WordValid = 1'b0;
    logic        WordReady;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        CfgReset;
    logic [1:0]  Grant;
    logic        Timeout;

    int tests = 0;
    int failures = 0;
    bit checking = 0;

    always #5 CLK = ~CLK;

    config_port_arbiter #(.NumberOfRows(Rows), .DesyncFlag(Flag), .TimeoutCycles(Tmo)) dut (
        .CLK(CLK), .Reset(Reset),
        .ByteData(ByteData), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .WordData(WordData), .WordValid(WordValid), .WordReady(WordReady),
        .WriteData(WriteData), .WriteStrobe(WriteStrobe), .CfgReset(CfgReset),
        .Grant(Grant), .Timeout(Timeout)
    );

    // Session model: owner 0 none / 1 word / 2 byte; rowsLeft==0 after sync means a header is due.
    int          m_owner = 0;
    bit          m_lastByte = 1;
    int          m_armLeft = 0;
    bit          m_accepting = 0;
    bit          m_closing = 0;
    bit          m_synced = 0;
    int          m_rowsLeft = 0;
    int          m_idle = 0;
    logic [7:0]  m_bytes[$];
    bit          m_strobe = 0;
    logic [31:0] m_data = 32'h0;
    bit          m_timeout = 0;

    task automatic modelReset();
        m_owner = 0; m_lastByte = 1; m_armLeft = 0; m_accepting = 0; m_closing = 0;
        m_synced = 0; m_rowsLeft = 0; m_idle = 0; m_bytes.delete();
        m_strobe = 0; m_data = 32'h0; m_timeout = 0;
    endtask

    task automatic modelStep();
        bit wAcc, bAcc, newStrobe, endSess, tmo;
        logic [31:0] newData;
        wAcc = m_accepting && (m_owner == 1) && WordValid;
        bAcc = m_accepting && (m_owner == 2) && ByteValid;
        newStrobe = 0; newData = m_data; endSess = 0; tmo = 0;
        if (wAcc) begin
            newStrobe = 1; newData = WordData;
        end
        if (bAcc) begin
            m_bytes.push_back(ByteData);
            if (m_bytes.size() == 4) begin
                newData = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                newStrobe = 1;
                m_bytes.delete();
            end
        end
        if (m_closing) begin
            m_lastByte = (m_owner == 2);
            m_owner = 0; m_closing = 0; m_bytes.delete();
        end else if (m_owner == 0) begin
            if (WordValid && !(ByteValid && !m_lastByte)) m_owner = 1;
            else if (ByteValid) m_owner = 2;
            if (m_owner != 0) m_armLeft = 2;
        end else if (!m_accepting) begin
            m_armLeft--;
            if (m_armLeft == 0) begin
                m_accepting = 1; m_synced = 0; m_rowsLeft = 0; m_idle = 0;
            end
        end else begin
            if (wAcc || bAcc) m_idle = 0;
            else begin
                m_idle++;
                tmo = (m_idle == Tmo);
            end
            if (!tmo && m_strobe) begin
                if (!m_synced) m_synced = (m_data == Sync);
                else if (m_rowsLeft == 0) begin
                    if (m_data[Flag]) endSess = 1;
                    else m_rowsLeft = Rows;
                end else m_rowsLeft--;
            end
            if (tmo || endSess) begin
                m_accepting = 0; m_closing = 1;
            end
        end
        m_timeout = tmo; m_strobe = newStrobe; m_data = newData;
    endtask

    always @(posedge CLK or posedge Reset) begin
        if (Reset) modelReset();
        else modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            checkOutput("Grant", {30'd0, Grant}, (m_owner == 1) ? 32'd1 : (m_owner == 2) ? 32'd2 : 32'd0);
            checkOutput("CfgReset", {31'd0, CfgReset}, {31'd0, m_armLeft > 0});
            checkOutput("WordReady", {31'd0, WordReady}, {31'd0, m_accepting && m_owner == 1});
            checkOutput("ByteReady", {31'd0, ByteReady}, {31'd0, m_accepting && m_owner == 2});
            checkOutput("WriteStrobe", {31'd0, WriteStrobe}, {31'd0, m_strobe});
            checkOutput("Timeout", {31'd0, Timeout}, {31'd0, m_timeout});
            if (m_strobe) checkOutput("WriteData", WriteData, m_data);
        end
    end

    logic [31:0] obsQ[$];
    int tmoCount = 0;
    int cfgCount = 0;
    int brDuringWord = 0;

    always @(negedge CLK) begin
        if (WriteStrobe === 1'b1) obsQ.push_back(WriteData);
        if (Timeout === 1'b1) tmoCount++;
        if (CfgReset === 1'b1) cfgCount++;
        if (Grant === 2'b01 && ByteReady === 1'b1) brDuringWord++;
    end

    task automatic applyStimulus(input bit isByte, input logic [31:0] d);
        int n = 0;
        if (isByte) begin
            ByteData = d[7:0]; ByteValid = 1'b1;
        end else begin
            WordData = d; WordValid = 1'b1;
        end
        while (!(isByte ? ByteReady : WordReady)) begin
            if (n == 200) begin
                tests++; failures++;
                $display("[TB] FAIL handshake: no ready after %0d cycles, expected ready", n);
                break;
            end
            @(posedge CLK); #1;
            n++;
        end
        @(posedge CLK); #1;
        if (isByte) ByteValid = 1'b0;
        else WordValid = 1'b0;
    endtask

    task automatic waitGrant(input int limit);
        int n = 0;
        while (Grant == 2'b00 && n < limit) begin
            @(posedge CLK); #1;
            n++;
        end
        if (Grant == 2'b00) begin
            tests++; failures++;
            $display("[TB] FAIL grant wait: Grant stayed 00 for %0d cycles, expected a grant", n);
        end
    endtask

    task automatic sendBytes(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) applyStimulus(1'b1, {24'd0, w[k*8 +: 8]});
    endtask

    logic [31:0] expWords[$];

    initial begin
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checking = 1;
        checkOutput("reset Grant", {30'd0, Grant}, 32'd0);
        checkOutput("reset CfgReset", {31'd0, CfgReset}, 32'd0);
        checkOutput("reset WriteStrobe", {31'd0, WriteStrobe}, 32'd0);
        checkOutput("reset Ready", {30'd0, WordReady, ByteReady}, 32'd0);
        Reset = 1'b0;

        // Contention plus full word session; byte port keeps requesting throughout.
        obsQ.delete(); cfgCount = 0; brDuringWord = 0;
        ByteData = 8'hFA; ByteValid = 1'b1;
        WordData = Sync; WordValid = 1'b1;
        waitGrant(20);
        checkOutput("first grant word", {30'd0, Grant}, 32'd1);
        expWords = {Sync, 32'h0000_0001};
        for (int i = 0; i < Rows; i++) expWords.push_back((i == 3) ? 32'h0010_0000 : 32'hC0DE_0000 + i);
        expWords.push_back(32'h0010_0000);
        foreach (expWords[i]) applyStimulus(1'b0, expWords[i]);
        @(posedge CLK); #1;
        checkOutput("grant held in close", {30'd0, Grant}, 32'd1);
        @(posedge CLK); #1;
        checkOutput("grant released", {30'd0, Grant}, 32'd0);
        checkOutput("word strobe count", obsQ.size(), 32'd13);
        for (int i = 0; i < 13 && i < obsQ.size(); i++) checkOutput("word data", obsQ[i], expWords[i]);
        checkOutput("CfgReset width", cfgCount, 32'd2);
        checkOutput("ByteReady in word session", brDuringWord, 32'd0);

        // Byte port wins next; pack the sync word.
        obsQ.delete();
        sendBytes(Sync);
        checkOutput("byte grant", {30'd0, Grant}, 32'd2);
        checkOutput("packed strobe", {31'd0, WriteStrobe}, 32'd1);
        checkOutput("packed data", WriteData, Sync);

        // Two stray bytes, then silence until timeout.
        applyStimulus(1'b1, 32'h12);
        applyStimulus(1'b1, 32'h34);
        obsQ.delete(); tmoCount = 0;
        for (int n = 0; n < Tmo + 50 && Grant != 2'b00; n++) begin
            @(posedge CLK); #1;
        end
        checkOutput("timeout release", {30'd0, Grant}, 32'd0);
        checkOutput("timeout pulses", tmoCount, 32'd1);
        checkOutput("timeout no strobe", obsQ.size(), 32'd0);

        // Fresh byte session must start with an empty packer, then desync via bytes.
        sendBytes(Sync);
        checkOutput("empty packer data", WriteData, Sync);
        checkOutput("empty packer strobe", {31'd0, WriteStrobe}, 32'd1);
        sendBytes(32'h0010_0000);
        repeat (3) @(posedge CLK);
        #1;

        // Short word session so the word port becomes last granted.
        applyStimulus(1'b0, Sync);
        applyStimulus(1'b0, 32'h0010_0000);
        repeat (3) @(posedge CLK);
        #1;

        // Byte session into FRAME, then asynchronous reset mid-cycle.
        sendBytes(Sync);
        sendBytes(32'h0000_0001);
        sendBytes(32'hA5A5_0001);
        sendBytes(32'hA5A5_0002);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async Grant", {30'd0, Grant}, 32'd0);
        checkOutput("async strobe", {31'd0, WriteStrobe}, 32'd0);
        checkOutput("async Ready", {30'd0, WordReady, ByteReady}, 32'd0);
        checkOutput("async CfgReset", {31'd0, CfgReset}, 32'd0);
        ByteData = 8'h11; ByteValid = 1'b1;
        WordData = Sync; WordValid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        waitGrant(20);
        checkOutput("post-reset grant word", {30'd0, Grant}, 32'd1);
        WordValid = 1'b0; ByteValid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
